// File: rtl/i2c_pkg.sv
// Shared constants for the I2C master: FIFO sizing, byte width and
// status-register bit positions used by the APB slave.
package i2c_pkg;

    localparam int BYTE_W          = 8;
    localparam int FIFO_DEPTH_LOG2 = 3;

    localparam int TX_FULL  = 0;
    localparam int TX_EMPTY = 1;
    localparam int RX_FULL  = 2;
    localparam int RX_EMPTY = 3;
    localparam int RX_OVF   = 4;
    localparam int TX_OVF   = 5;

endpackage

// File: rtl/i2c_fifo_if.sv
// Push/pop/status bundle between a FIFO user (master) and i2c_fifo (slave).
interface i2c_fifo_if
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH      = BYTE_W,
    parameter int FIFO_ADDR_WIDTH = FIFO_DEPTH_LOG2
);
    logic                       flush_i;
    logic                       wr_en_i;
    logic [DATA_WIDTH-1:0]      wr_data_i;
    logic                       rd_en_i;
    logic                       clr_err_i;
    logic [DATA_WIDTH-1:0]      rd_data_o;
    logic                       full_o;
    logic                       empty_o;
    logic [FIFO_ADDR_WIDTH:0]   count_o;
    logic                       overflow_o;
    logic                       underflow_o;

    modport master (
        output flush_i, wr_en_i, wr_data_i, rd_en_i, clr_err_i,
        input  rd_data_o, full_o, empty_o, count_o,
        input  overflow_o, underflow_o
    );

    modport slave (
        input  flush_i, wr_en_i, wr_data_i, rd_en_i, clr_err_i,
        output rd_data_o, full_o, empty_o, count_o,
        output overflow_o, underflow_o
    );
endinterface

// File: rtl/i2c_fifo_ram.sv
// DEPTH x DATA_WIDTH flop array: one synchronous write, one async read.
module i2c_fifo_ram
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH = BYTE_W,
    parameter int ADDR_WIDTH = FIFO_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/i2c_fifo.sv
// First-word-fall-through byte FIFO for the I2C TX/RX paths.
// Sticky overflow/underflow flags exist only with I2C_FIFO_ERR_FLAGS_EN.
module i2c_fifo
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH      = BYTE_W,
    parameter int FIFO_ADDR_WIDTH = FIFO_DEPTH_LOG2
) (
    input  logic         pclk_i,
    input  logic         preset_ni,
    i2c_fifo_if.slave    bus
);
    localparam int AW = FIFO_ADDR_WIDTH;
    localparam logic [AW:0] ONE = 1;

    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [AW:0]           count;
    logic                  empty;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;
    logic [DATA_WIDTH-1:0] rdata;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
                && (wr_ptr[AW] != rd_ptr[AW]);

    // A pop in the same cycle frees the slot a push into a full FIFO needs
    assign do_pop  = bus.rd_en_i && !empty && !bus.flush_i;
    assign do_push = bus.wr_en_i && (!full || bus.rd_en_i)
                  && !bus.flush_i;

    i2c_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk   (pclk_i),
        .we    (do_push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (bus.wr_data_i),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ONE;
            if (do_pop)  rd_ptr <= rd_ptr + ONE;
            if (do_push && !do_pop)      count <= count + ONE;
            else if (do_pop && !do_push) count <= count - ONE;
        end
    end

    assign bus.rd_data_o = empty ? '0 : rdata;
    assign bus.full_o    = full;
    assign bus.empty_o   = empty;
    assign bus.count_o   = count;

`ifdef I2C_FIFO_ERR_FLAGS_EN
    logic ovf;
    logic unf;
    logic ovf_set;
    logic unf_set;

    assign ovf_set = bus.wr_en_i && full && !bus.rd_en_i
                  && !bus.flush_i;
    assign unf_set = bus.rd_en_i && empty && !bus.flush_i;

    // Set has priority over clear
    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ovf <= ovf_set || (ovf && !bus.clr_err_i);
            unf <= unf_set || (unf && !bus.clr_err_i);
        end
    end

    assign bus.overflow_o  = ovf;
    assign bus.underflow_o = unf;
`else
    logic unused_clr_err;
    assign unused_clr_err  = bus.clr_err_i;
    assign bus.overflow_o  = 1'b0;
    assign bus.underflow_o = 1'b0;
`endif
endmodule

// File: tb/tb_i2c_fifo.sv
// Directed self-checking bench for i2c_fifo (either macro setting).
module tb_i2c_fifo;
    import i2c_pkg::*;

`ifdef I2C_FIFO_ERR_FLAGS_EN
    localparam logic FLG = 1'b1;
`else
    localparam logic FLG = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [7:0] q[$];
    logic [7:0] exp_b;

    i2c_fifo_if #(.DATA_WIDTH(8), .FIFO_ADDR_WIDTH(3)) bus ();

    i2c_fifo #(
        .DATA_WIDTH      (8),
        .FIFO_ADDR_WIDTH (3)
    ) dut (
        .pclk_i    (clk),
        .preset_ni (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flush_i   = 1'b0;
        bus.wr_en_i   = 1'b0;
        bus.rd_en_i   = 1'b0;
        bus.clr_err_i = 1'b0;
        bus.wr_data_i = 8'h00;
    endtask

    task automatic push(input logic [7:0] d);
        bus.wr_en_i   = 1'b1;
        bus.wr_data_i = d;
        cyc();
        idle();
    endtask

    task automatic pop();
        bus.rd_en_i = 1'b1;
        cyc();
        idle();
    endtask

    task automatic clr();
        bus.clr_err_i = 1'b1;
        cyc();
        idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        rst_n = 1'b0;
        #22;
        chk("rst_empty", bus.empty_o, 1);
        chk("rst_rd", bus.rd_data_o, 0);
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("idle_empty", bus.empty_o, 1);
        chk("idle_full", bus.full_o, 0);
        chk("idle_count", bus.count_o, 0);
        chk("idle_rd", bus.rd_data_o, 0);
        chk("idle_ovf", bus.overflow_o, 0);
        chk("idle_unf", bus.underflow_o, 0);

        // Fill, then push into full
        for (int i = 0; i < 8; i++) push(8'hA1 + 8'(i));
        chk("fill_full", bus.full_o, 1);
        chk("fill_count", bus.count_o, 8);
        chk("fill_rd", bus.rd_data_o, 8'hA1);
        push(8'hFF);
        chk("drop_count", bus.count_o, 8);
        chk("drop_rd", bus.rd_data_o, 8'hA1);
        chk("drop_ovf", bus.overflow_o, 32'(FLG));
        clr();
        chk("clr_ovf", bus.overflow_o, 0);

        // Drain in order
        for (int i = 0; i < 8; i++) begin
            chk("drain_rd", bus.rd_data_o, 8'hA1 + 8'(i));
            pop();
        end
        chk("drain_empty", bus.empty_o, 1);
        chk("drain_rd0", bus.rd_data_o, 0);
        chk("drain_cnt", bus.count_o, 0);
        pop();
        chk("unf_set", bus.underflow_o, 32'(FLG));
        chk("unf_cnt", bus.count_o, 0);
        clr();
        chk("unf_clr", bus.underflow_o, 0);

        // Push+pop while full
        for (int i = 0; i < 8; i++) push(8'hB0 + 8'(i));
        bus.wr_en_i   = 1'b1;
        bus.rd_en_i   = 1'b1;
        bus.wr_data_i = 8'hC0;
        cyc();
        idle();
        chk("pp_full_cnt", bus.count_o, 8);
        chk("pp_full_full", bus.full_o, 1);
        chk("pp_full_rd", bus.rd_data_o, 8'hB1);
        chk("pp_full_ovf", bus.overflow_o, 0);
        for (int i = 0; i < 8; i++) begin
            exp_b = (i == 7) ? 8'hC0 : 8'hB1 + 8'(i);
            chk("pp_drain", bus.rd_data_o, 32'(exp_b));
            pop();
        end
        chk("pp_drain_empty", bus.empty_o, 1);

        // Push+pop while empty
        bus.wr_en_i   = 1'b1;
        bus.rd_en_i   = 1'b1;
        bus.wr_data_i = 8'h5A;
        cyc();
        idle();
        chk("pp_emp_cnt", bus.count_o, 1);
        chk("pp_emp_rd", bus.rd_data_o, 8'h5A);
        chk("pp_emp_unf", bus.underflow_o, 32'(FLG));
        clr();
        pop();
        chk("pp_emp_done", bus.empty_o, 1);

        // Wrap with occupancy held at 3
        q.delete();
        for (int i = 0; i < 3; i++) begin
            push(8'hD0 + 8'(i));
            q.push_back(8'hD0 + 8'(i));
        end
        for (int i = 0; i < 20; i++) begin
            chk("wrap_rd", bus.rd_data_o, 32'(q[0]));
            bus.wr_en_i   = 1'b1;
            bus.rd_en_i   = 1'b1;
            bus.wr_data_i = 8'h40 + 8'(i);
            q.push_back(8'h40 + 8'(i));
            void'(q.pop_front());
            cyc();
            idle();
            chk("wrap_cnt", bus.count_o, 3);
            chk("wrap_full", bus.full_o, 0);
        end
        while (q.size() > 0) begin
            chk("wrap_tail", bus.rd_data_o, 32'(q[0]));
            void'(q.pop_front());
            pop();
        end
        chk("wrap_empty", bus.empty_o, 1);

        // Flush beats a same-cycle push
        for (int i = 0; i < 5; i++) push(8'hF0 + 8'(i));
        chk("fl_pre_cnt", bus.count_o, 5);
        bus.flush_i   = 1'b1;
        bus.wr_en_i   = 1'b1;
        bus.wr_data_i = 8'h99;
        cyc();
        idle();
        chk("fl_cnt", bus.count_o, 0);
        chk("fl_empty", bus.empty_o, 1);
        chk("fl_rd", bus.rd_data_o, 0);

        // Asynchronous reset mid-stream
        push(8'h11);
        push(8'h22);
        chk("ar_pre_cnt", bus.count_o, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_cnt", bus.count_o, 0);
        chk("ar_empty", bus.empty_o, 1);
        chk("ar_rd", bus.rd_data_o, 0);
        #2 rst_n = 1'b1;
        cyc();
        chk("ar_post_empty", bus.empty_o, 1);
        chk("ar_post_full", bus.full_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
